// File: rtl/ctr_arb_pkg.sv
// Shared types and constants for the counter-cell priority arbiter.
// Imported by ctr_prio_enc and ctr_priority_arb.
package ctr_arb_pkg;

    localparam int NCELLS_MAX = 32;

    localparam logic DIR_PLUS  = 1'b0;
    localparam logic DIR_MINUS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // One-hot decode of a cell index, used to build per-cell clear masks.
    function automatic logic [NCELLS_MAX-1:0] idx_to_onehot(input logic [4:0] idx);
        logic [NCELLS_MAX-1:0] oh;
        oh = {{(NCELLS_MAX-1){1'b0}}, 1'b1} << idx;
        return oh;
    endfunction

endpackage

// File: rtl/ctr_prio_enc.sv
// Lowest-index-first priority encoder, purely combinational.
// Returns the index of the lowest set request bit and whether any bit is set.
module ctr_prio_enc
    import ctr_arb_pkg::*;
#(
    parameter int N = 20,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         vld
);

    // Scan from the top down so the lowest set bit is the last to overwrite idx.
    always_comb begin
        idx = {W{1'b0}};
        vld = |req;
        for (int i = N - 1; i >= 0; i--) begin
            idx = req[i] ? W'(i) : idx;
        end
    end

endmodule

// File: rtl/ctr_priority_arb.sv
// Counter-cell priority arbiter: latches plus/minus increment pulses per cell and
// grants one cell per memory cycle (cell 0 highest). Optional macro: CTR_ARB_MINUS_EN.
module ctr_priority_arb
    import ctr_arb_pkg::*;
#(
    parameter int NCELLS = 20,
    parameter int IDXW   = $clog2(NCELLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCELLS-1:0] pinc_req,
    input  logic [NCELLS-1:0] minc_req,
    input  logic              mct,
    input  logic              inhibit,
    input  logic              done,
    output logic              busy,
    output logic              grant_vld,
    output logic [IDXW-1:0]   grant_idx,
    output logic              grant_dir,
    output logic [NCELLS-1:0] pend,
    output logic              ovr
);

    arb_state_t        state_r;
    arb_state_t        state_s;

    logic [NCELLS-1:0] p_r;
    logic [NCELLS-1:0] p_s;
    logic [NCELLS-1:0] clr_p_s;
    logic [NCELLS-1:0] pend_s;
    logic [NCELLS-1:0] sel_oh_s;
    logic [IDXW-1:0]   sel_idx_s;
    logic              sel_vld_s;
    logic              sel_dir_s;
    logic              take_s;
    logic              ovr_s;

    logic              busy_r;
    logic              grant_vld_r;
    logic [IDXW-1:0]   grant_idx_r;
    logic              grant_dir_r;
    logic              ovr_r;

    ctr_prio_enc #(
        .N (NCELLS),
        .W (IDXW)
    ) u_prio_enc (
        .req (pend_s),
        .idx (sel_idx_s),
        .vld (sel_vld_s)
    );

    // One-hot mask of the cell the encoder picked.
    always_comb begin
        sel_oh_s = NCELLS'(idx_to_onehot(5'(sel_idx_s)));
    end

    // Grant FSM next-state; take_s marks the IDLE->GRANT edge.
    always_comb begin
        state_s = state_r;
        take_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mct && !inhibit && sel_vld_s) begin
                    state_s = ST_GRANT;
                    take_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

`ifdef CTR_ARB_MINUS_EN
    logic [NCELLS-1:0] m_r;
    logic [NCELLS-1:0] m_s;
    logic [NCELLS-1:0] clr_m_s;
    logic [NCELLS-1:0] p_raw_s;
    logic [NCELLS-1:0] m_raw_s;
    logic [NCELLS-1:0] cancel_s;

    // Latch update with grant clear, set-wins, and plus/minus cancellation.
    always_comb begin
        sel_dir_s = (|(p_r & sel_oh_s)) ? DIR_PLUS : DIR_MINUS;
        clr_p_s   = {NCELLS{1'b0}};
        clr_m_s   = {NCELLS{1'b0}};
        if (take_s) begin
            if (sel_dir_s == DIR_PLUS) begin
                clr_p_s = sel_oh_s;
            end else begin
                clr_m_s = sel_oh_s;
            end
        end else begin
            clr_p_s = {NCELLS{1'b0}};
            clr_m_s = {NCELLS{1'b0}};
        end
        p_raw_s  = (p_r & ~clr_p_s) | pinc_req;
        m_raw_s  = (m_r & ~clr_m_s) | minc_req;
        cancel_s = p_raw_s & m_raw_s;
        p_s      = p_raw_s & ~cancel_s;
        m_s      = m_raw_s & ~cancel_s;
        ovr_s    = |((pinc_req & p_r & ~clr_p_s) | (minc_req & m_r & ~clr_m_s));
        pend_s   = p_r | m_r;
    end

    // Minus-direction latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_r <= {NCELLS{1'b0}};
        end else begin
            m_r <= m_s;
        end
    end
`else
    logic unused_minc_s;

    // Plus-only latch update; minus requests are discarded.
    always_comb begin
        unused_minc_s = ^minc_req;
        sel_dir_s     = DIR_PLUS;
        if (take_s) begin
            clr_p_s = sel_oh_s;
        end else begin
            clr_p_s = {NCELLS{1'b0}};
        end
        p_s    = (p_r & ~clr_p_s) | pinc_req;
        ovr_s  = |(pinc_req & p_r & ~clr_p_s);
        pend_s = p_r;
    end
`endif

    // State, plus latches and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            p_r         <= {NCELLS{1'b0}};
            busy_r      <= 1'b0;
            grant_vld_r <= 1'b0;
            grant_idx_r <= {IDXW{1'b0}};
            grant_dir_r <= DIR_PLUS;
            ovr_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            p_r         <= p_s;
            busy_r      <= (state_s != ST_IDLE);
            grant_vld_r <= (state_s == ST_GRANT);
            ovr_r       <= ovr_s;
            if (take_s) begin
                grant_idx_r <= sel_idx_s;
                grant_dir_r <= sel_dir_s;
            end else begin
                grant_idx_r <= grant_idx_r;
                grant_dir_r <= grant_dir_r;
            end
        end
    end

    assign busy      = busy_r;
    assign grant_vld = grant_vld_r;
    assign grant_idx = grant_idx_r;
    assign grant_dir = grant_dir_r;
    assign pend      = pend_s;
    assign ovr       = ovr_r;

endmodule

// File: tb/tb_ctr_priority_arb.sv
// Directed self-checking bench for ctr_priority_arb (NCELLS = 20).
// Minus-specific steps are built only when CTR_ARB_MINUS_EN is defined.
module tb_ctr_priority_arb;

    localparam int NCELLS = 20;
    localparam int IDXW   = $clog2(NCELLS);

    logic              clk;
    logic              rst;
    logic [NCELLS-1:0] pinc_req;
    logic [NCELLS-1:0] minc_req;
    logic              mct;
    logic              inhibit;
    logic              done;
    logic              busy;
    logic              grant_vld;
    logic [IDXW-1:0]   grant_idx;
    logic              grant_dir;
    logic [NCELLS-1:0] pend;
    logic              ovr;

    int compared   = 0;
    int mismatched = 0;

    ctr_priority_arb #(.NCELLS(NCELLS)) dut (
        .clk       (clk),
        .rst       (rst),
        .pinc_req  (pinc_req),
        .minc_req  (minc_req),
        .mct       (mct),
        .inhibit   (inhibit),
        .done      (done),
        .busy      (busy),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .grant_dir (grant_dir),
        .pend      (pend),
        .ovr       (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b0;
        pinc_req = {NCELLS{1'b1}};
        minc_req = {NCELLS{1'b0}};
        mct      = 1'b0;
        inhibit  = 1'b0;
        done     = 1'b0;

        // Reset held with requests hammering
        tick();
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_vld", 32'(grant_vld), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        chk("rst_dir", 32'(grant_dir), 32'h0);
        chk("rst_ovr", 32'(ovr), 32'h0);
        mct = 1'b1;
        tick();
        chk("rst_pend2", 32'(pend), 32'h0);
        chk("rst_vld2", 32'(grant_vld), 32'h0);
        mct      = 1'b0;
        pinc_req = {NCELLS{1'b0}};
        rst      = 1'b1;
        tick();

        // Single request on cell 3 then its grant
        pinc_req = 20'h00008;
        tick();
        pinc_req = 20'h0;
        chk("req3_pend", 32'(pend), 32'h8);
        mct = 1'b1;
        tick();
        mct = 1'b0;
        chk("g3_vld", 32'(grant_vld), 32'h1);
        chk("g3_idx", 32'(grant_idx), 32'd3);
        chk("g3_busy", 32'(busy), 32'h1);
        chk("g3_pend", 32'(pend), 32'h0);
        tick();
        chk("g3_vld_off", 32'(grant_vld), 32'h0);
        chk("g3_busy_wait", 32'(busy), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("g3_busy_off", 32'(busy), 32'h0);

        // Priority: cells 5 and 2 together
        pinc_req = 20'h00024;
        tick();
        pinc_req = 20'h0;
        chk("pri_pend", 32'(pend), 32'h24);
        mct = 1'b1;
        tick();
        mct = 1'b0;
        chk("pri_vld_a", 32'(grant_vld), 32'h1);
        chk("pri_idx_a", 32'(grant_idx), 32'd2);
        chk("pri_dir_a", 32'(grant_dir), 32'h0);
        chk("pri_pend_a", 32'(pend), 32'h20);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        mct  = 1'b1;
        tick();
        mct = 1'b0;
        chk("pri_vld_b", 32'(grant_vld), 32'h1);
        chk("pri_idx_b", 32'(grant_idx), 32'd5);
        chk("pri_pend_b", 32'(pend), 32'h0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("pri_busy_off", 32'(busy), 32'h0);

`ifdef CTR_ARB_MINUS_EN
        // Cancel: plus on cell 4, minus two cycles later
        pinc_req = 20'h00010;
        tick();
        pinc_req = 20'h0;
        tick();
        minc_req = 20'h00010;
        tick();
        minc_req = 20'h0;
        chk("cxl_pend", 32'(pend), 32'h0);
        chk("cxl_ovr", 32'(ovr), 32'h0);
        mct = 1'b1;
        tick();
        mct = 1'b0;
        chk("cxl_vld", 32'(grant_vld), 32'h0);
        chk("cxl_busy", 32'(busy), 32'h0);

        // Minus grant on cell 6
        minc_req = 20'h00040;
        tick();
        minc_req = 20'h0;
        chk("min_pend", 32'(pend), 32'h40);
        mct = 1'b1;
        tick();
        mct = 1'b0;
        chk("min_vld", 32'(grant_vld), 32'h1);
        chk("min_idx", 32'(grant_idx), 32'd6);
        chk("min_dir", 32'(grant_dir), 32'h1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
`else
        // Minus requests have no effect in the plus-only build
        minc_req = 20'h00010;
        tick();
        minc_req = 20'h0;
        chk("minoff_pend", 32'(pend), 32'h0);
        mct = 1'b1;
        tick();
        mct = 1'b0;
        chk("minoff_vld", 32'(grant_vld), 32'h0);
        chk("minoff_busy", 32'(busy), 32'h0);
`endif

        // Overrun: two plus pulses on cell 1
        pinc_req = 20'h00002;
        tick();
        pinc_req = 20'h0;
        chk("ovr_first", 32'(ovr), 32'h0);
        pinc_req = 20'h00002;
        tick();
        pinc_req = 20'h0;
        chk("ovr_second", 32'(ovr), 32'h1);
        chk("ovr_pend", 32'(pend), 32'h2);
        tick();
        chk("ovr_pulse_end", 32'(ovr), 32'h0);
        mct = 1'b1;
        tick();
        mct = 1'b0;
        chk("ovr_gvld", 32'(grant_vld), 32'h1);
        chk("ovr_gidx", 32'(grant_idx), 32'd1);
        chk("ovr_gpend", 32'(pend), 32'h0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        mct  = 1'b1;
        tick();
        mct = 1'b0;
        chk("ovr_single", 32'(grant_vld), 32'h0);

        // Inhibit, done in GRANT, mct in WAIT
        pinc_req = 20'h00001;
        tick();
        pinc_req = 20'h0;
        chk("inh_pend", 32'(pend), 32'h1);
        inhibit = 1'b1;
        mct     = 1'b1;
        tick();
        mct = 1'b0;
        chk("inh_vld", 32'(grant_vld), 32'h0);
        chk("inh_busy", 32'(busy), 32'h0);
        inhibit = 1'b0;
        mct     = 1'b1;
        tick();
        chk("inh_gvld", 32'(grant_vld), 32'h1);
        chk("inh_gidx", 32'(grant_idx), 32'd0);
        done     = 1'b1;
        pinc_req = 20'h00080;
        tick();
        done     = 1'b0;
        pinc_req = 20'h0;
        chk("grant_done_busy", 32'(busy), 32'h1);
        chk("grant_done_vld", 32'(grant_vld), 32'h0);
        tick();
        mct = 1'b0;
        chk("wait_mct_busy", 32'(busy), 32'h1);
        chk("wait_mct_vld", 32'(grant_vld), 32'h0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("wait_done_busy", 32'(busy), 32'h0);
        chk("no_queue_vld", 32'(grant_vld), 32'h0);
        chk("no_queue_pend", 32'(pend), 32'h80);
        mct = 1'b1;
        tick();
        mct = 1'b0;
        chk("g7_idx", 32'(grant_idx), 32'd7);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;

        // Set-wins on cell 0
        pinc_req = 20'h00001;
        tick();
        mct = 1'b1;
        tick();
        mct      = 1'b0;
        pinc_req = 20'h0;
        chk("sw_vld", 32'(grant_vld), 32'h1);
        chk("sw_idx", 32'(grant_idx), 32'd0);
        chk("sw_pend", 32'(pend), 32'h1);
        chk("sw_ovr", 32'(ovr), 32'h0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        mct  = 1'b1;
        tick();
        mct = 1'b0;
        chk("sw_regrant", 32'(grant_vld), 32'h1);
        chk("sw_pend_clr", 32'(pend), 32'h0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;

        // Reset asserted mid-grant
        pinc_req = 20'h00A00;
        tick();
        pinc_req = 20'h0;
        mct      = 1'b1;
        tick();
        mct = 1'b0;
        chk("mid_vld", 32'(grant_vld), 32'h1);
        chk("mid_idx", 32'(grant_idx), 32'd9);
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(grant_vld), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_idx", 32'(grant_idx), 32'h0);
        chk("mid_rst_pend", 32'(pend), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_pend", 32'(pend), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
